// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and default widths shared by the ALU datapath.
package alu_pkg;

   localparam int ALU_WIDTH   = 32;
   localparam int ALU_SHAMT_W = $clog2(ALU_WIDTH);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_SRL  = 3'b100;
   localparam logic [2:0] OP_SRA  = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;
   localparam logic [2:0] OP_SLTU = 3'b111;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational log-stage right shifter, zero or sign fill.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH   = ALU_WIDTH,
   parameter int SHAMT_W = ALU_SHAMT_W
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               arith,
   output logic [WIDTH-1:0]   y
);

   logic             fill;
   logic [WIDTH-1:0] stg [SHAMT_W+1];

   assign fill   = arith & a[WIDTH-1];
   assign stg[0] = a;

   // Stage i shifts by 2**i when shamt bit i is set.
   for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
      localparam int S = 1 << i;
      assign stg[i+1] = shamt[i] ? {{S{fill}}, stg[i][WIDTH-1:S]}
                                 : stg[i];
   end

   assign y = stg[SHAMT_W];

endmodule

// File: rtl/alu_core.sv
// alu_core: registered integer ALU, one-cycle latency.
// Define ALU_FLAGS_EN to add registered zero/ovf outputs.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH   = ALU_WIDTH,
   parameter int SHAMT_W = ALU_SHAMT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALUOp,
   output logic [WIDTH-1:0] C,
   output logic             out_valid
`ifdef ALU_FLAGS_EN
   ,
   output logic             zero,
   output logic             ovf
`endif
);

   localparam int M = WIDTH - 1;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] res;
   logic             slt;
   logic             sltu;

   assign sum  = A + B;
   assign diff = A - B;
   assign slt  = $signed(A) < $signed(B);
   assign sltu = A < B;

   alu_shifter #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_shifter (
      .a     (A),
      .shamt (B[SHAMT_W-1:0]),
      .arith (ALUOp == OP_SRA),
      .y     (sh)
   );

   always_comb begin
      res = '0;
      unique case (ALUOp)
         OP_ADD:  res = sum;
         OP_SUB:  res = diff;
         OP_AND:  res = A & B;
         OP_OR:   res = A | B;
         OP_SRL:  res = sh;
         OP_SRA:  res = sh;
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, slt};
         OP_SLTU: res = {{(WIDTH-1){1'b0}}, sltu};
         default: res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         C         <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) C <= res;
      end
   end

`ifdef ALU_FLAGS_EN
   logic res_ovf;

   // Overflow: operands agree in sign (ADD) or differ (SUB) and result flips.
   always_comb begin
      res_ovf = 1'b0;
      if (ALUOp == OP_ADD)
         res_ovf = ~(A[M] ^ B[M]) & (sum[M] ^ A[M]);
      else if (ALUOp == OP_SUB)
         res_ovf = (A[M] ^ B[M]) & (diff[M] ^ A[M]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero <= 1'b0;
         ovf  <= 1'b0;
      end else if (in_valid) begin
         zero <= (res == '0);
         ovf  <= res_ovf;
      end
   end
`endif

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: scoreboard bench for alu_core.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu_core;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  ALUOp;
   logic [31:0] C;
   logic        out_valid;
`ifdef ALU_FLAGS_EN
   logic        zero;
   logic        ovf;
`endif

   typedef struct packed {
      logic [31:0] c;
      logic        z;
      logic        v;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [31:0] c;
      logic        v;
   } vec_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_c;

   alu_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .ALUOp     (ALUOp),
      .C         (C),
      .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
      ,
      .zero      (zero),
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic [2:0]  op);
      exp_t   e;
      longint s;
      longint mx;
      logic [4:0] sa;
      mx  = 2147483647;
      sa  = b[4:0];
      e.v = 1'b0;
      e.c = '0;
      case (op)
         OP_ADD: begin
            s   = longint'($signed(a)) + longint'($signed(b));
            e.c = a + b;
            e.v = (s > mx) || (s < -mx - 1);
         end
         OP_SUB: begin
            s   = longint'($signed(a)) - longint'($signed(b));
            e.c = a - b;
            e.v = (s > mx) || (s < -mx - 1);
         end
         OP_AND:  e.c = a & b;
         OP_OR:   e.c = a | b;
         OP_SRL:  e.c = a >> sa;
         OP_SRA:  e.c = $unsigned($signed(a) >>> sa);
         OP_SLT:  e.c = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: e.c = (a < b) ? 32'd1 : 32'd0;
      endcase
      e.z = (e.c == 32'd0);
      return e;
   endfunction

   task automatic drive(input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] op);
      @(negedge clk);
      in_valid = v;
      A        = a;
      B        = b;
      ALUOp    = op;
   endtask

   task automatic test_reset;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      A        = '0;
      B        = '0;
      ALUOp    = OP_ADD;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (C !== 32'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset C=%h out_valid=%b expected C=0 out_valid=0",
                  C, out_valid);
      end
      @(negedge clk);
      rst_n  = 1'b1;
      last_c = '0;
   endtask

   task automatic test_shift;
      exp_t e;
      vec_t tv[12];
      tv[0]  = '{32'hFFFF0000, 32'h3,  OP_SRA, 32'hFFFFE000, 1'b0};
      tv[1]  = '{32'hFFFF0000, 32'h3,  OP_SRA, 32'hFFFFE000, 1'b0};
      tv[2]  = '{32'hFFFF0000, 32'h3,  OP_SRA, 32'hFFFFE000, 1'b0};
      tv[3]  = '{32'hFFFF0000, 32'h3,  OP_SRA, 32'hFFFFE000, 1'b0};
      tv[4]  = '{32'hFFFF0000, 32'h3,  OP_SRA, 32'hFFFFE000, 1'b0};
      tv[5]  = '{32'hFFFF0000, 32'h3,  OP_SRL, 32'h1FFFE000, 1'b0};
      tv[6]  = '{32'hFFFF0000, 32'h23, OP_SRL, 32'h1FFFE000, 1'b0};
      tv[7]  = '{32'hFFFF0000, 32'h23, OP_SRA, 32'hFFFFE000, 1'b0};
      tv[8]  = '{32'h89ABCDEF, 32'h0,  OP_SRA, 32'h89ABCDEF, 1'b0};
      tv[9]  = '{32'h80000000, 32'h1F, OP_SRA, 32'hFFFFFFFF, 1'b0};
      tv[10] = '{32'h80000000, 32'h1F, OP_SRL, 32'h00000001, 1'b0};
      tv[11] = '{32'h7FFFFFFF, 32'h1F, OP_SRA, 32'h00000000, 1'b0};
      foreach (tv[i]) begin
         drive(1'b1, tv[i].a, tv[i].b, tv[i].op);
         q.push_back({tv[i].c, tv[i].c == 32'd0, tv[i].v});
         @(posedge clk);
         #1;
         e = q.pop_front();
         checks++;
         if (C !== e.c || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL shift[%0d] C=%h out_valid=%b expected C=%h out_valid=1",
                     i, C, out_valid, e.c);
         end
`ifdef ALU_FLAGS_EN
         checks++;
         if (zero !== e.z || ovf !== e.v) begin
            errors++;
            $display("FAIL shift_flags[%0d] zero=%b ovf=%b expected %b %b",
                     i, zero, ovf, e.z, e.v);
         end
`endif
         last_c = e.c;
      end
   endtask

   task automatic test_arith;
      exp_t e;
      vec_t tv[5];
      tv[0] = '{32'hFFFFFFFF, 32'h1, OP_ADD, 32'h00000000, 1'b0};
      tv[1] = '{32'h7FFFFFFF, 32'h1, OP_ADD, 32'h80000000, 1'b1};
      tv[2] = '{32'h00000000, 32'h1, OP_SUB, 32'hFFFFFFFF, 1'b0};
      tv[3] = '{32'h80000000, 32'h1, OP_SUB, 32'h7FFFFFFF, 1'b1};
      tv[4] = '{32'h12345678, 32'h11111111, OP_ADD, 32'h23456789, 1'b0};
      foreach (tv[i]) begin
         drive(1'b1, tv[i].a, tv[i].b, tv[i].op);
         q.push_back({tv[i].c, tv[i].c == 32'd0, tv[i].v});
         @(posedge clk);
         #1;
         e = q.pop_front();
         checks++;
         if (C !== e.c || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL arith[%0d] C=%h out_valid=%b expected C=%h out_valid=1",
                     i, C, out_valid, e.c);
         end
`ifdef ALU_FLAGS_EN
         checks++;
         if (zero !== e.z || ovf !== e.v) begin
            errors++;
            $display("FAIL arith_flags[%0d] zero=%b ovf=%b expected %b %b",
                     i, zero, ovf, e.z, e.v);
         end
`endif
         last_c = e.c;
      end
   endtask

   task automatic test_logic;
      exp_t e;
      vec_t tv[7];
      tv[0] = '{32'hF0F0F0F0, 32'h0FF00FF0, OP_AND,  32'h00F000F0, 1'b0};
      tv[1] = '{32'hF0F0F0F0, 32'h0FF00FF0, OP_OR,   32'hFFF0FFF0, 1'b0};
      tv[2] = '{32'hFFFFFFFF, 32'h00000001, OP_SLT,  32'h00000001, 1'b0};
      tv[3] = '{32'hFFFFFFFF, 32'h00000001, OP_SLTU, 32'h00000000, 1'b0};
      tv[4] = '{32'h00000001, 32'hFFFFFFFF, OP_SLT,  32'h00000000, 1'b0};
      tv[5] = '{32'h00000001, 32'hFFFFFFFF, OP_SLTU, 32'h00000001, 1'b0};
      tv[6] = '{32'hF0F0F0F0, 32'h0F0F0F0F, OP_AND,  32'h00000000, 1'b0};
      foreach (tv[i]) begin
         drive(1'b1, tv[i].a, tv[i].b, tv[i].op);
         q.push_back({tv[i].c, tv[i].c == 32'd0, tv[i].v});
         @(posedge clk);
         #1;
         e = q.pop_front();
         checks++;
         if (C !== e.c || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL logic[%0d] C=%h out_valid=%b expected C=%h out_valid=1",
                     i, C, out_valid, e.c);
         end
`ifdef ALU_FLAGS_EN
         checks++;
         if (zero !== e.z || ovf !== e.v) begin
            errors++;
            $display("FAIL logic_flags[%0d] zero=%b ovf=%b expected %b %b",
                     i, zero, ovf, e.z, e.v);
         end
`endif
         last_c = e.c;
      end
   endtask

   task automatic test_valid_gating;
      drive(1'b1, 32'h0000BEEF, 32'h00010000, OP_OR);
      last_c = 32'h0001BEEF;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, $urandom, $urandom, 3'(i));
         @(posedge clk);
         #1;
         checks++;
         if (C !== last_c || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL gating[%0d] C=%h out_valid=%b expected C=%h out_valid=0",
                     i, C, out_valid, last_c);
         end
      end
   endtask

   task automatic test_reset_mid;
      drive(1'b1, 32'd5, 32'd6, OP_ADD);
      @(posedge clk);
      drive(1'b1, 32'd1, 32'd2, OP_ADD);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (C !== 32'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_async C=%h out_valid=%b expected C=0 out_valid=0",
                  C, out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (C !== 32'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold C=%h out_valid=%b expected C=0 out_valid=0",
                  C, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (C !== 32'd3 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_release C=%h out_valid=%b expected C=3 out_valid=1",
                  C, out_valid);
      end
      last_c = 32'd3;
   endtask

   task automatic test_back_to_back;
      exp_t        e;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      for (int i = 0; i < 40; i++) begin
         a  = $urandom;
         b  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         op = 3'($urandom_range(0, 7));
         drive(1'b1, a, b, op);
         q.push_back(model(a, b, op));
         @(posedge clk);
         #1;
         e = q.pop_front();
         checks++;
         if (C !== e.c || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b[%0d] op=%0d a=%h b=%h C=%h expected C=%h",
                     i, op, a, b, C, e.c);
         end
`ifdef ALU_FLAGS_EN
         checks++;
         if (zero !== e.z || ovf !== e.v) begin
            errors++;
            $display("FAIL b2b_flags[%0d] zero=%b ovf=%b expected %b %b",
                     i, zero, ovf, e.z, e.v);
         end
`endif
         last_c = e.c;
      end
   endtask

   initial begin
      test_reset();
      test_shift();
      test_arith();
      test_logic();
      test_valid_gating();
      test_reset_mid();
      test_back_to_back();
      drive(1'b0, '0, '0, OP_ADD);
      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
